// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core.
// Contents: the instruction-memory map (PC_RESET, IM_WORDS, IM_AW), the
// NOP encoding used for pipeline bubbles, and the fetch state enum.
package cpu_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;
    localparam int unsigned IM_AW    = 12;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_range_chk.sv
// Combinational legal-address check, shared by instruction fetch and the
// data-side address checker.
// A PC is legal when it is word aligned and lies within
// [BASE, BASE + 4*WORDS - 4]. The comparison is unsigned 32-bit, so a
// PC that wrapped past 2^32 falls below BASE and is rejected.
// Ports:
//   pc    in   32  byte address to check
//   legal out  1   1 = aligned and inside the window
module pc_range_chk
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE  = cpu_pkg::PC_RESET,
    parameter int unsigned WORDS = cpu_pkg::IM_WORDS
) (
    input  logic [31:0] pc,
    output logic        legal
);

    localparam logic [31:0] LAST = BASE + 32'(WORDS * 4) - 32'd4;

    assign legal = (pc[1:0] == 2'b00) && (pc >= BASE) && (pc <= LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the pipelined MIPS core.
// Owns the fetch PC, addresses the instruction memory combinationally,
// captures the IF/ID pipeline register, and applies hazard stalls and
// ID-stage redirects with one architectural delay slot. Fetch halts
// (sticky until reset) on an illegal PC.
// Ports:
//   clk            in   1      clock, rising edge
//   reset          in   1      synchronous, active-high
//   stall_i        in   1      hold PC and IF/ID this cycle
//   redir_valid_i  in   1      taken branch/jump/jr in ID this cycle
//   redir_target_i in   32     redirect target byte address
//   im_addr_o      out  IM_AW  IM word address, combinational from pc_f_o
//   im_rdata_i     in   32     IM read data, same cycle
//   pc_f_o         out  32     current fetch PC
//   ifid_valid_o   out  1      IF/ID holds a real instruction
//   ifid_pc_o      out  32     PC of the IF/ID instruction
//   ifid_instr_o   out  32     IF/ID instruction word
//   fault_o        out  1      sticky: fetch halted on illegal PC
//   fault_pc_o     out  32     offending PC, valid while fault_o=1
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
    parameter int unsigned IM_WORDS = cpu_pkg::IM_WORDS,
    parameter int unsigned IM_AW    = cpu_pkg::IM_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             redir_valid_i,
    input  logic [31:0]      redir_target_i,
    output logic [IM_AW-1:0] im_addr_o,
    input  logic [31:0]      im_rdata_i,
    output logic [31:0]      pc_f_o,
    output logic             ifid_valid_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             fault_o,
    output logic [31:0]      fault_pc_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_q, pend_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic         pc_legal;

    pc_range_chk #(
        .BASE  (PC_RESET),
        .WORDS (IM_WORDS)
    ) u_pc_chk (
        .pc    (pc_q),
        .legal (pc_legal)
    );

    // Word offset from the IM base; bits above IM_AW are dropped by the cast.
    assign im_addr_o = IM_AW'((pc_q - PC_RESET) >> 2);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        tgt_d        = tgt_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;

        case (state_q)
            RUN: begin
                if (!stall_i) begin
                    if (pc_legal) begin
                        // The word fetched this cycle is the delay slot of any
                        // redirect raised now, so it is always captured.
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = im_rdata_i;
                        // A redirect latched during a stall belongs to the branch
                        // that was held in ID and takes priority.
                        if (pend_q)
                            pc_d = tgt_q;
                        else if (redir_valid_i)
                            pc_d = redir_target_i;
                        else
                            pc_d = pc_q + 32'd4;
                        pend_d = 1'b0;
                    end else begin
                        state_d      = HALT;
                        fault_d      = 1'b1;
                        fault_pc_d   = pc_q;
                        ifid_valid_d = 1'b0;
                        ifid_pc_d    = '0;
                        ifid_instr_d = NOP;
                    end
                end else if (redir_valid_i && !pend_q) begin
                    // Only the first redirect of a stall is kept; repeats come
                    // from the same branch being held in ID.
                    pend_d = 1'b1;
                    tgt_d  = redir_target_i;
                end
            end
            HALT: begin
                // Everything holds until reset.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= PC_RESET;
            pend_q       <= 1'b0;
            tgt_q        <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            fault_q      <= 1'b0;
            fault_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            tgt_q        <= tgt_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    assign pc_f_o       = pc_q;
    assign ifid_valid_o = ifid_valid_q && (state_q == RUN);
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign fault_o      = fault_q;
    assign fault_pc_o   = fault_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. A small behavioural model tracks
// PC, pending redirect and halt; every capture it predicts is pushed to a
// scoreboard queue and popped when the IF/ID register updates.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redir_valid_i;
    logic [31:0] redir_target_i;
    logic [11:0] im_addr_o;
    logic [31:0] im_rdata_i;
    logic [31:0] pc_f_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;

    fetch_sequencer #(
        .PC_RESET (32'h0000_3000),
        .IM_WORDS (4096),
        .IM_AW    (12)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .redir_valid_i  (redir_valid_i),
        .redir_target_i (redir_target_i),
        .im_addr_o      (im_addr_o),
        .im_rdata_i     (im_rdata_i),
        .pc_f_o         (pc_f_o),
        .ifid_valid_o   (ifid_valid_o),
        .ifid_pc_o      (ifid_pc_o),
        .ifid_instr_o   (ifid_instr_o),
        .fault_o        (fault_o),
        .fault_pc_o     (fault_pc_o)
    );

    always #5 clk = ~clk;

    // IM contents: each word tagged with its own word index.
    assign im_rdata_i = 32'hA500_0000 | {20'h0, im_addr_o};

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - 32'h0000_3000;
        return 32'hA500_0000 | {20'h0, off[13:2]};
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } cap_t;

    cap_t        sb[$];
    logic [31:0] m_pc, m_tgt, m_fpc, m_ipc;
    logic        m_pend, m_halt, m_valid;

    task automatic do_reset(input logic st);
        reset          = 1'b1;
        stall_i        = st;
        redir_valid_i  = 1'b1;
        redir_target_i = 32'h0000_3400;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        stall_i       = 1'b0;
        redir_valid_i = 1'b0;
        m_pc    = 32'h0000_3000;
        m_tgt   = '0;
        m_fpc   = '0;
        m_ipc   = '0;
        m_pend  = 1'b0;
        m_halt  = 1'b0;
        m_valid = 1'b0;
        sb.delete();
        check("rst_pc", pc_f_o, 32'h0000_3000);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_fault_pc", fault_pc_o, 32'd0);
        check("rst_valid", 32'(ifid_valid_o), 32'd0);
        check("rst_ifid_pc", ifid_pc_o, 32'd0);
    endtask

    task automatic cycle(input logic st, input logic rv, input logic [31:0] rt);
        logic        legal;
        logic        capt;
        logic [31:0] off;
        cap_t        e;
        stall_i        = st;
        redir_valid_i  = rv;
        redir_target_i = rt;
        #1;
        off = m_pc - 32'h0000_3000;
        check("im_addr", {20'h0, im_addr_o}, {20'h0, off[13:2]});
        legal = (m_pc[1:0] == 2'b00) && (m_pc >= 32'h0000_3000) && (m_pc <= 32'h0000_6FFC);
        capt  = 1'b0;
        if (!m_halt) begin
            if (!st) begin
                if (legal) begin
                    e.pc    = m_pc;
                    e.instr = instr_of(m_pc);
                    sb.push_back(e);
                    capt = 1'b1;
                    if (m_pend)  m_pc = m_tgt;
                    else if (rv) m_pc = rt;
                    else         m_pc = m_pc + 32'd4;
                    m_pend = 1'b0;
                end else begin
                    m_halt = 1'b1;
                    m_fpc  = m_pc;
                end
            end else if (rv && !m_pend) begin
                m_pend = 1'b1;
                m_tgt  = rt;
            end
        end
        @(posedge clk);
        #1;
        check("pc_f", pc_f_o, m_pc);
        check("fault", 32'(fault_o), 32'(m_halt));
        if (m_halt) begin
            check("fault_pc", fault_pc_o, m_fpc);
            check("halt_valid", 32'(ifid_valid_o), 32'd0);
        end else if (capt) begin
            e = sb.pop_front();
            check("cap_valid", 32'(ifid_valid_o), 32'd1);
            check("cap_pc", ifid_pc_o, e.pc);
            check("cap_instr", ifid_instr_o, e.instr);
            m_ipc   = e.pc;
            m_valid = 1'b1;
        end else begin
            check("hold_valid", 32'(ifid_valid_o), 32'(m_valid));
            if (m_valid) check("hold_pc", ifid_pc_o, m_ipc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        stall_i        = 1'b0;
        redir_valid_i  = 1'b0;
        redir_target_i = '0;

        do_reset(1'b0);

        // Free-running fetch; redirect raised in the cycle pc_f=0x3008.
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t2_pc_before_redir", pc_f_o, 32'h0000_3008);
        cycle(1'b0, 1'b1, 32'h0000_3100);
        check("t2_delay_slot", ifid_pc_o, 32'h0000_3008);
        cycle(1'b0, 1'b0, 32'h0);
        check("t2_target", ifid_pc_o, 32'h0000_3100);
        cycle(1'b0, 1'b0, 32'h0);
        check("t2_target_plus4", ifid_pc_o, 32'h0000_3104);

        // Two stalled cycles; the second redirect must be ignored.
        cycle(1'b1, 1'b1, 32'h0000_3200);
        cycle(1'b1, 1'b1, 32'h0000_3300);
        check("t3_frozen_pc", pc_f_o, 32'h0000_3108);
        check("t3_frozen_ifid", ifid_pc_o, 32'h0000_3104);
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_next_fetch", pc_f_o, 32'h0000_3200);
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_target_cap", ifid_pc_o, 32'h0000_3200);

        // Misaligned target: no fault while stalled, fault on first free cycle.
        cycle(1'b0, 1'b1, 32'h0000_3002);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_3000);
        check("t4_no_fault_stalled", 32'(fault_o), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t4_fault", 32'(fault_o), 32'd1);
        check("t4_fault_pc", fault_pc_o, 32'h0000_3002);
        for (int i = 0; i < 10; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'h0000_3000 + (32'($urandom_range(0, 4095)) << 2));
        check("t4_still_halted", pc_f_o, 32'h0000_3002);

        // Reset out of HALT.
        do_reset(1'b0);

        // Run up to the top of IM; 0x7000 must fault.
        cycle(1'b0, 1'b1, 32'h0000_6FF0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 32'h0);
        check("t5_last_word", ifid_pc_o, 32'h0000_6FFC);
        check("t5_last_instr", ifid_instr_o, 32'hA500_0FFF);
        cycle(1'b0, 1'b0, 32'h0);
        check("t5_fault_pc", fault_pc_o, 32'h0000_7000);

        // Reset out of HALT with stall asserted.
        do_reset(1'b1);

        // Random legal traffic, then reset in the middle of a stall.
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  32'h0000_3000 + (32'($urandom_range(0, 4095)) << 2));
        cycle(1'b1, 1'b1, 32'h0000_3500);
        do_reset(1'b1);
        cycle(1'b0, 1'b0, 32'h0);
        check("t6_first_after_rst", ifid_pc_o, 32'h0000_3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
